// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: major opcodes, immediate-format select
// encoding and the canonical NOP used to fill empty decode-queue slots.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_CSR = 3'b101
   } imm_sel_e;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode decode: immediate-format select for the immediate
// generator plus an illegal flag for opcodes this core does not implement.
module imm_sel_decode
   import riscv_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [2:0] o_imm_sel,
   output logic       o_illegal
);

   // Register-register ops and FENCE carry no immediate; select I as a harmless default.
   always_comb begin
      o_imm_sel = IMM_I;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_IMM, OP_LOAD, OP_JALR: o_imm_sel = IMM_I;
         OP_STORE:                 o_imm_sel = IMM_S;
         OP_BRANCH:                o_imm_sel = IMM_B;
         OP_JAL:                   o_imm_sel = IMM_J;
         OP_LUI, OP_AUIPC:         o_imm_sel = IMM_U;
         OP_SYSTEM:                o_imm_sel = IMM_CSR;
         OP_OP, OP_FENCE:          o_imm_sel = IMM_I;
         default: begin
            o_imm_sel = IMM_I;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Two-entry fetch-to-decode queue. The head slot drives the outputs directly,
// so nothing on in_* reaches out_* without passing through a register.
module decode_queue_ctrl
   import riscv_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_inst,
   input  logic [DW-1:0] in_pc,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_inst,
   output logic [DW-1:0] out_pc,
   output logic [2:0]    out_imm_sel,
   output logic          out_illegal
);

   localparam logic [1:0]    FULL_CNT = 2'(DEPTH);
   localparam logic [DW-1:0] NOP_W    = DW'(NOP_INST);

   logic [1:0]    r_count;
   logic [DW-1:0] r_head_inst, r_head_pc, r_tail_inst, r_tail_pc;
   logic [2:0]    r_head_sel, r_tail_sel;
   logic          r_head_ill, r_tail_ill;

   logic [1:0]    w_count_nx;
   logic [DW-1:0] w_head_inst_nx, w_head_pc_nx, w_tail_inst_nx, w_tail_pc_nx;
   logic [2:0]    w_head_sel_nx, w_tail_sel_nx;
   logic          w_head_ill_nx, w_tail_ill_nx;

   logic [2:0]    w_new_sel;
   logic          w_new_ill;
   logic          w_push, w_pop;

   imm_sel_decode u_imm_sel_decode (
      .i_opcode  (in_inst[6:0]),
      .o_imm_sel (w_new_sel),
      .o_illegal (w_new_ill)
   );

   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   // Vacated slots are refilled with NOP so the empty-queue outputs come straight from the head.
   always_comb begin
      w_count_nx     = r_count;
      w_head_inst_nx = r_head_inst;
      w_head_pc_nx   = r_head_pc;
      w_head_sel_nx  = r_head_sel;
      w_head_ill_nx  = r_head_ill;
      w_tail_inst_nx = r_tail_inst;
      w_tail_pc_nx   = r_tail_pc;
      w_tail_sel_nx  = r_tail_sel;
      w_tail_ill_nx  = r_tail_ill;
      if (flush) begin
         w_count_nx     = 2'd0;
         w_head_inst_nx = NOP_W;
         w_head_pc_nx   = '0;
         w_head_sel_nx  = IMM_I;
         w_head_ill_nx  = 1'b0;
         w_tail_inst_nx = NOP_W;
         w_tail_pc_nx   = '0;
         w_tail_sel_nx  = IMM_I;
         w_tail_ill_nx  = 1'b0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  w_count_nx     = 2'd1;
                  w_head_inst_nx = in_inst;
                  w_head_pc_nx   = in_pc;
                  w_head_sel_nx  = w_new_sel;
                  w_head_ill_nx  = w_new_ill;
               end else begin
                  w_count_nx = 2'd0;
               end
            end
            2'd1: begin
               case ({w_push, w_pop})
                  2'b11: begin
                     w_head_inst_nx = in_inst;
                     w_head_pc_nx   = in_pc;
                     w_head_sel_nx  = w_new_sel;
                     w_head_ill_nx  = w_new_ill;
                  end
                  2'b10: begin
                     w_count_nx     = 2'd2;
                     w_tail_inst_nx = in_inst;
                     w_tail_pc_nx   = in_pc;
                     w_tail_sel_nx  = w_new_sel;
                     w_tail_ill_nx  = w_new_ill;
                  end
                  2'b01: begin
                     w_count_nx     = 2'd0;
                     w_head_inst_nx = NOP_W;
                     w_head_pc_nx   = '0;
                     w_head_sel_nx  = IMM_I;
                     w_head_ill_nx  = 1'b0;
                  end
                  default: w_count_nx = 2'd1;
               endcase
            end
            2'd2: begin
               if (w_pop) begin
                  w_count_nx     = 2'd1;
                  w_head_inst_nx = r_tail_inst;
                  w_head_pc_nx   = r_tail_pc;
                  w_head_sel_nx  = r_tail_sel;
                  w_head_ill_nx  = r_tail_ill;
                  w_tail_inst_nx = NOP_W;
                  w_tail_pc_nx   = '0;
                  w_tail_sel_nx  = IMM_I;
                  w_tail_ill_nx  = 1'b0;
               end else begin
                  w_count_nx = 2'd2;
               end
            end
            default: begin
               w_count_nx     = 2'd0;
               w_head_inst_nx = NOP_W;
               w_head_pc_nx   = '0;
               w_head_sel_nx  = IMM_I;
               w_head_ill_nx  = 1'b0;
               w_tail_inst_nx = NOP_W;
               w_tail_pc_nx   = '0;
               w_tail_sel_nx  = IMM_I;
               w_tail_ill_nx  = 1'b0;
            end
         endcase
      end
   end

   // Slot and count registers; reset dominates flush, push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= 2'd0;
         r_head_inst <= NOP_W;
         r_head_pc   <= '0;
         r_head_sel  <= IMM_I;
         r_head_ill  <= 1'b0;
         r_tail_inst <= NOP_W;
         r_tail_pc   <= '0;
         r_tail_sel  <= IMM_I;
         r_tail_ill  <= 1'b0;
      end else begin
         r_count     <= w_count_nx;
         r_head_inst <= w_head_inst_nx;
         r_head_pc   <= w_head_pc_nx;
         r_head_sel  <= w_head_sel_nx;
         r_head_ill  <= w_head_ill_nx;
         r_tail_inst <= w_tail_inst_nx;
         r_tail_pc   <= w_tail_pc_nx;
         r_tail_sel  <= w_tail_sel_nx;
         r_tail_ill  <= w_tail_ill_nx;
      end
   end

   assign out_inst    = r_head_inst;
   assign out_pc      = r_head_pc;
   assign out_imm_sel = r_head_sel;
   assign out_illegal = r_head_ill;

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Self-checking bench for decode_queue_ctrl: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_decode_queue_ctrl;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  sel;
      logic        ill;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = 32'h0;
   logic [31:0] in_pc = 32'h0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  out_imm_sel;
   logic        out_illegal;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t q[$];

   decode_queue_ctrl #(.DW(32), .DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .out_imm_sel (out_imm_sel),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   // Reference decode: look the opcode up in the format table.
   function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] pc);
      logic [6:0] ops  [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                                7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};
      logic [2:0] sels [11] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                                3'd4, 3'd4, 3'd5, 3'd0, 3'd0};
      ent_t e;
      e.inst = inst;
      e.pc   = pc;
      e.sel  = 3'd0;
      e.ill  = 1'b1;
      for (int k = 0; k < 11; k++) begin
         if (inst[6:0] == ops[k]) begin
            e.sel = sels[k];
            e.ill = 1'b0;
         end
      end
      return e;
   endfunction

   function automatic logic        e_valid(); return q.size() != 0; endfunction
   function automatic logic        e_ready(); return q.size() != 2; endfunction
   function automatic logic [31:0] e_inst();  return (q.size() != 0) ? q[0].inst : 32'h13; endfunction
   function automatic logic [31:0] e_pc();    return (q.size() != 0) ? q[0].pc : 32'h0; endfunction
   function automatic logic [2:0]  e_sel();   return (q.size() != 0) ? q[0].sel : 3'd0; endfunction
   function automatic logic        e_ill();   return (q.size() != 0) ? q[0].ill : 1'b0; endfunction

   // One clock: update the model from the inputs as seen at the edge, then settle.
   task automatic step();
      bit do_push, do_pop;
      do_push = in_valid && (q.size() != 2) && !flush;
      do_pop  = (q.size() != 0) && out_ready && !flush;
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(mk(in_inst, in_pc));
      end
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); rst = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      n_tests++; if (out_inst !== 32'h13 || out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 00000013/0", out_inst, out_pc); end
      n_tests++; if (out_imm_sel !== 3'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b/%b want 000/0", out_imm_sel, out_illegal); end
   endtask

   task automatic test_single_push();
      out_ready = 1'b0;
      push(32'h00A00093, 32'h0);
      n_tests++; if (out_valid !== 1'b1 || out_inst !== 32'h00A00093) begin n_fail++; $display("FAIL single_head: got %b/%h want 1/00a00093", out_valid, out_inst); end
      n_tests++; if (out_imm_sel !== 3'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL single_sel: got %b/%b want 000/0", out_imm_sel, out_illegal); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_inst !== 32'h13) begin n_fail++; $display("FAIL single_drain: got %b/%h want 0/00000013", out_valid, out_inst); end
   endtask

   task automatic test_fill_order();
      out_ready = 1'b0;
      push(32'h00112223, 32'h4);
      push(32'hFE000EE3, 32'h8);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", in_ready); end
      n_tests++; if (out_imm_sel !== 3'd1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL fill_first: got %b/%h want 001/4", out_imm_sel, out_pc); end
      in_valid = 1'b1; in_inst = 32'h00000037; in_pc = 32'hC;
      step(); in_valid = 1'b0;
      n_tests++; if (out_inst !== 32'h00112223 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_stable: got %h/%b want 00112223/0", out_inst, in_ready); end
      out_ready = 1'b1; step();
      n_tests++; if (out_imm_sel !== 3'd2 || out_pc !== 32'h8) begin n_fail++; $display("FAIL fill_second: got %b/%h want 010/8", out_imm_sel, out_pc); end
      step(); out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_no_dup: got %b want 0", out_valid); end
   endtask

   task automatic test_push_pop();
      out_ready = 1'b0;
      push(32'h00000013, 32'h10);
      in_valid = 1'b1; in_inst = 32'h0000006F; in_pc = 32'h20; out_ready = 1'b1;
      step(); in_valid = 1'b0; out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_count: got %b/%b want 1/1", out_valid, in_ready); end
      n_tests++; if (out_imm_sel !== 3'd3 || out_pc !== 32'h20) begin n_fail++; $display("FAIL pushpop_head: got %b/%h want 011/20", out_imm_sel, out_pc); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask

   task automatic test_flush();
      push(32'h00000013, 32'h30);
      push(32'h00000033, 32'h34);
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000017; out_ready = 1'b1;
      step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_inst !== 32'h13) begin n_fail++; $display("FAIL flush_head: got %b/%h want 0/00000013", out_valid, out_inst); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_csr_illegal();
      push(32'h30001073, 32'h40);
      push(32'hFFFFFFFF, 32'h44);
      n_tests++; if (out_imm_sel !== 3'd5 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL csr_sel: got %b/%b want 101/0", out_imm_sel, out_illegal); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      n_tests++; if (out_imm_sel !== 3'd0 || out_illegal !== 1'b1 || out_pc !== 32'h44) begin n_fail++; $display("FAIL illegal_sel: got %b/%b/%h want 000/1/44", out_imm_sel, out_illegal, out_pc); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      push(32'h00000013, 32'h50);
      push(32'h00000013, 32'h54);
      rst = 1'b1; out_ready = 1'b1;
      step(); rst = 1'b0; out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_head: got %b/%h want 0/0", out_valid, out_pc); end
      step();
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b/%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                               7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};
      logic [31:0] r;
      int          errs;
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         r         = $urandom();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 49) == 0);
         in_inst   = ($urandom_range(0, 4) == 0) ? r : {r[31:7], ops[$urandom_range(0, 10)]};
         in_pc     = $urandom();
         step();
         n_tests++;
         if (out_valid !== e_valid() || in_ready !== e_ready() || out_inst !== e_inst() ||
             out_pc !== e_pc() || out_imm_sel !== e_sel() || out_illegal !== e_ill()) begin
            n_fail++;
            if (errs < 10) $display("FAIL random_c%0d: got v%b r%b %h %h %b %b want v%b r%b %h %h %b %b", c,
               out_valid, in_ready, out_inst, out_pc, out_imm_sel, out_illegal,
               e_valid(), e_ready(), e_inst(), e_pc(), e_sel(), e_ill());
            errs++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single_push();
      test_fill_order();
      test_push_pop();
      test_flush();
      test_csr_illegal();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1);
   end

endmodule
